// File: rtl/audio_envelope.sv
// ADSR envelope generator scaling 8-bit offset-binary samples around 0x80.
// Latency: sample_data_o is registered, 1 clk after sample_data_i/env register.
// Backpressure: none, it is a free-running streaming stage that accepts a sample every clk.
module audio_envelope #(
  parameter int RATE_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              gate_i,
  input  logic [RATE_W-1:0] attack_rate_i,
  input  logic [RATE_W-1:0] decay_rate_i,
  input  logic [7:0]        sustain_lvl_i,
  input  logic [RATE_W-1:0] release_rate_i,
  input  logic [7:0]        sample_data_i,
  output logic [7:0]        sample_data_o,
  output logic [7:0]        env_level_o,
  output logic [2:0]        env_state_o,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        env_q, env_d;
  logic [RATE_W-1:0] acc_q, acc_d;
  logic [RATE_W-1:0] rate;
  logic [RATE_W:0]   sum;
  logic              tick;

  logic signed [16:0] smp_s;
  logic signed [16:0] env_s;
  logic signed [16:0] prod;
  logic [7:0]         scaled;

  // Rate accumulator: only the ramping states feed it a non-zero increment,
  // so IDLE/SUSTAIN naturally keep acc at 0 and never tick.
  always_comb begin
    rate = '0;
    case (state_q)
      ST_ATTACK:  rate = attack_rate_i;
      ST_DECAY:   rate = decay_rate_i;
      ST_RELEASE: rate = release_rate_i;
      default:    rate = '0;
    endcase
    sum  = {1'b0, acc_q} + {1'b0, rate};
    tick = sum[RATE_W];
  end

  // Next-state and envelope update; every transition restarts the accumulator.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    acc_d   = sum[RATE_W-1:0];
    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (gate_i) state_d = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate_i) begin
          state_d = ST_RELEASE;
          acc_d   = '0;
        end else if (env_q == 8'hFF) begin
          state_d = ST_DECAY;
          acc_d   = '0;
        end else if (tick) begin
          env_d = env_q + 8'd1;
        end
      end
      ST_DECAY: begin
        if (!gate_i) begin
          state_d = ST_RELEASE;
          acc_d   = '0;
        end else if (env_q <= sustain_lvl_i) begin
          state_d = ST_SUSTAIN;
          acc_d   = '0;
        end else if (tick) begin
          env_d = env_q - 8'd1;
        end
      end
      ST_SUSTAIN: begin
        acc_d = '0;
        if (!gate_i) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (gate_i) begin
          // Retrigger continues from the current level rather than restarting at 0.
          state_d = ST_ATTACK;
          acc_d   = '0;
        end else if (env_q == 8'h00) begin
          state_d = ST_IDLE;
          acc_d   = '0;
        end else if (tick) begin
          env_d = env_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        env_d   = 8'h00;
        acc_d   = '0;
      end
    endcase
  end

  // State, envelope and accumulator registers; reset aborts any note at once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      env_q   <= 8'h00;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
      acc_q   <= acc_d;
    end
  end

  // Signed scaling around the 0x80 midpoint; floor shift keeps result in 0x00..0xFE.
  always_comb begin
    smp_s  = $signed({9'b0, sample_data_i}) - 17'sd128;
    env_s  = $signed({9'b0, env_q});
    prod   = smp_s * env_s;
    scaled = 8'(prod >>> 8) + 8'h80;
  end

  // Output sample register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sample_data_o <= 8'h80;
    end else begin
      sample_data_o <= scaled;
    end
  end

  assign env_level_o = env_q;
  assign env_state_o = state_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_envelope.sv
// Directed + randomized bench for audio_envelope against a behavioural ADSR model.
module tb_audio_envelope;

  localparam int RATE_W = 16;
  localparam int ACC_MOD = 1 << RATE_W;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              gate_i;
  logic [RATE_W-1:0] attack_rate_i;
  logic [RATE_W-1:0] decay_rate_i;
  logic [7:0]        sustain_lvl_i;
  logic [RATE_W-1:0] release_rate_i;
  logic [7:0]        sample_data_i;
  logic [7:0]        sample_data_o;
  logic [7:0]        env_level_o;
  logic [2:0]        env_state_o;
  logic              busy_o;

  int tests = 0;
  int fails = 0;
  bit rand_smp = 1'b1;

  // Reference model state (plain integers)
  int m_state = 0;
  int m_env   = 0;
  int m_acc   = 0;
  int m_out   = 128;

  always #5 clk_i = ~clk_i;

  audio_envelope #(.RATE_W(RATE_W)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .gate_i         (gate_i),
    .attack_rate_i  (attack_rate_i),
    .decay_rate_i   (decay_rate_i),
    .sustain_lvl_i  (sustain_lvl_i),
    .release_rate_i (release_rate_i),
    .sample_data_i  (sample_data_i),
    .sample_data_o  (sample_data_o),
    .env_level_o    (env_level_o),
    .env_state_o    (env_state_o),
    .busy_o         (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div256(input int p);
    if (p >= 0) return p / 256;
    return -((-p + 255) / 256);
  endfunction

  // One clock of the ADSR rules applied to the inputs present at the edge.
  task automatic model_edge();
    int rate;
    int total;
    int nacc;
    bit tk;
    if (rst_i) begin
      m_state = 0; m_env = 0; m_acc = 0; m_out = 128;
      return;
    end
    m_out = 128 + floor_div256((int'(sample_data_i) - 128) * m_env);
    case (m_state)
      1: rate = int'(attack_rate_i);
      2: rate = int'(decay_rate_i);
      4: rate = int'(release_rate_i);
      default: rate = 0;
    endcase
    total = m_acc + rate;
    tk    = (total >= ACC_MOD);
    nacc  = total % ACC_MOD;
    case (m_state)
      0: if (gate_i) begin m_state = 1; nacc = 0; end
      1: begin
        if (!gate_i) begin m_state = 4; nacc = 0; end
        else if (m_env == 255) begin m_state = 2; nacc = 0; end
        else if (tk) m_env = m_env + 1;
      end
      2: begin
        if (!gate_i) begin m_state = 4; nacc = 0; end
        else if (m_env <= int'(sustain_lvl_i)) begin m_state = 3; nacc = 0; end
        else if (tk) m_env = m_env - 1;
      end
      3: begin
        nacc = 0;
        if (!gate_i) m_state = 4;
      end
      default: begin
        if (gate_i) begin m_state = 1; nacc = 0; end
        else if (m_env == 0) begin m_state = 0; nacc = 0; end
        else if (tk) m_env = m_env - 1;
      end
    endcase
    m_acc = nacc;
  endtask

  // Advance one clock, update the model, then compare all outputs away from the edge.
  task automatic tick_clk();
    if (rand_smp) sample_data_i = 8'($urandom);
    @(posedge clk_i);
    model_edge();
    #1;
    check("env_level", 32'(env_level_o), 32'(m_env));
    check("env_state", 32'(env_state_o), 32'(m_state));
    check("sample_out", 32'(sample_data_o), 32'(m_out));
    check("busy", 32'(busy_o), 32'(m_state != 0));
  endtask

  initial begin
    int n;

    // Reset with arbitrary inputs
    rst_i = 1'b1;
    gate_i = 1'($urandom);
    attack_rate_i = 16'($urandom);
    decay_rate_i = 16'($urandom);
    release_rate_i = 16'($urandom);
    sustain_lvl_i = 8'($urandom);
    sample_data_i = 8'($urandom);
    repeat (3) tick_clk();
    check("rst_sample", 32'(sample_data_o), 32'h80);
    check("rst_env", 32'(env_level_o), 32'h0);
    check("rst_state", 32'(env_state_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);

    // env = 0 in IDLE: every sample maps to silence
    rst_i = 1'b0;
    gate_i = 1'b0;
    repeat (8) begin
      tick_clk();
      check("env0_scale", 32'(sample_data_o), 32'h80);
    end

    // Attack at half rate: one step every 2nd clk
    attack_rate_i = 16'h8000;
    decay_rate_i = 16'h8000;
    release_rate_i = 16'h4000;
    sustain_lvl_i = 8'h40;
    gate_i = 1'b1;
    tick_clk();
    check("enter_attack", 32'(env_state_o), 32'd1);
    n = 0;
    while (env_level_o !== 8'hFF && n < 2000) begin tick_clk(); n++; end
    check("attack_clks", 32'(n), 32'd510);
    tick_clk();
    check("enter_decay", 32'(env_state_o), 32'd2);

    // Decay down to the sustain level
    n = 0;
    while (env_level_o !== 8'h40 && n < 2000) begin tick_clk(); n++; end
    check("decay_clks", 32'(n), 32'd382);
    tick_clk();
    check("enter_sustain", 32'(env_state_o), 32'd3);
    repeat (50) begin
      sustain_lvl_i = 8'($urandom);
      tick_clk();
    end
    check("sustain_hold", 32'(env_level_o), 32'h40);
    check("sustain_state", 32'(env_state_o), 32'd3);

    // Release from 0x40 at quarter rate
    gate_i = 1'b0;
    tick_clk();
    check("enter_release", 32'(env_state_o), 32'd4);
    n = 0;
    while (env_level_o !== 8'h00 && n < 2000) begin tick_clk(); n++; end
    check("release_clks", 32'(n), 32'd256);
    tick_clk();
    check("release_idle", 32'(env_state_o), 32'd0);
    check("release_busy", 32'(busy_o), 32'd0);

    // Full-scale envelope, frozen in DECAY by a zero rate
    sustain_lvl_i = 8'h40;
    gate_i = 1'b1;
    n = 0;
    while (env_level_o !== 8'hFF && n < 2000) begin tick_clk(); n++; end
    check("attack_again_bound", 32'(env_level_o), 32'hFF);
    decay_rate_i = 16'h0000;
    tick_clk();
    check("decay_frozen_state", 32'(env_state_o), 32'd2);
    rand_smp = 1'b0;
    sample_data_i = 8'hFF;
    tick_clk();
    check("scale_ff", 32'(sample_data_o), 32'hFE);
    sample_data_i = 8'h00;
    tick_clk();
    check("scale_00", 32'(sample_data_o), 32'h00);
    sample_data_i = 8'h80;
    tick_clk();
    check("scale_80", 32'(sample_data_o), 32'h80);
    rand_smp = 1'b1;
    repeat (1000) tick_clk();
    check("rate0_hold", 32'(env_level_o), 32'hFF);
    check("rate0_state", 32'(env_state_o), 32'd2);

    // Retrigger from RELEASE at 0x20, then reset mid-attack
    gate_i = 1'b0;
    n = 0;
    while (env_level_o !== 8'h20 && n < 2000) begin tick_clk(); n++; end
    check("release_to_20", 32'(env_level_o), 32'h20);
    gate_i = 1'b1;
    tick_clk();
    check("retrig_state", 32'(env_state_o), 32'd1);
    check("retrig_env", 32'(env_level_o), 32'h20);
    repeat (10) tick_clk();
    check("retrig_climb", 32'(env_level_o), 32'h25);
    rst_i = 1'b1;
    tick_clk();
    check("midnote_rst_state", 32'(env_state_o), 32'd0);
    check("midnote_rst_env", 32'(env_level_o), 32'h0);
    rst_i = 1'b0;

    // Randomized run: random rates, gate changes, sustain jitter, rare resets
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) begin
        attack_rate_i  = 16'($urandom_range(0, 65535));
        decay_rate_i   = 16'($urandom_range(0, 65535));
        release_rate_i = 16'($urandom_range(0, 65535));
        if ($urandom_range(0, 7) == 0) attack_rate_i = 16'h0;
      end
      if ($urandom_range(0, 63) == 0) gate_i = ~gate_i;
      sustain_lvl_i = 8'($urandom);
      rst_i = ($urandom_range(0, 499) == 0);
      tick_clk();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
